// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the IF-stage PC sequencer: default address width,
// instruction size and the sequencer state encoding.
package pc_sequencer_pkg;

  localparam int unsigned PC_ADDR_W   = 64;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_sequencer_redirect_buffer.sv
// redirect_buffer
// Remembers a taken-branch target that could not be applied in the cycle it
// resolved (no ack yet, or IF stalled) until the next completed fetch.
// Ports:
//   clk, reset    : clock, async active-high reset
//   capture       : a taken branch resolves this cycle
//   target_in     : its target address
//   clear         : a fetch completes this cycle; the redirect is consumed
//   pending       : a redirect is waiting to be applied
//   saved_target  : most recently captured target (last capture wins)
module redirect_buffer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [ADDR_W-1:0] target_in,
  input  logic              clear,
  output logic              pending,
  output logic [ADDR_W-1:0] saved_target
);

  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] target_q,  target_d;

  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    if (capture) begin
      target_d = target_in;
    end
    // A capture coinciding with a completed fetch is applied directly by the
    // sequencer, so clearing wins over setting.
    if (clear) begin
      pending_d = 1'b0;
    end else if (capture) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      target_q  <= '0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  assign pending      = pending_q;
  assign saved_target = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the architectural PC and sequences instruction fetch for the 5-stage
// pipeline: imem request/ack handshake, IF stalls, taken-branch redirects
// with IF/ID flush, sticky halt, and a retired-fetch counter.
// Ports:
//   clk, reset    : clock, async active-high reset
//   cur_address   : current PC (registered)
//   next_address  : PC+4 or branch target from program_counter
//   take_branch   : branch taken, qualified by br_valid
//   br_valid      : a branch resolves this cycle
//   stall         : hazard unit holds IF
//   halt          : stop fetching, sticky until reset
//   imem_req      : fetch request for cur_address
//   imem_ack      : instruction for cur_address returned this cycle
//   if_valid      : IF/ID write enable
//   flush         : kill IF/ID contents
//   fetch_count   : if_valid pulses since reset (wraps)
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = PC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] cur_address,
  input  logic [ADDR_W-1:0] next_address,
  input  logic              take_branch,
  input  logic              br_valid,
  input  logic              stall,
  input  logic              halt,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              if_valid,
  output logic              flush,
  output logic [CNT_W-1:0]  fetch_count
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              redirect_now;
  logic              fetch_fire;
  logic              redirect_pending;
  logic [ADDR_W-1:0] saved_target;

  redirect_buffer #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buffer (
    .clk          (clk),
    .reset        (reset),
    .capture      (redirect_now),
    .target_in    (next_address),
    .clear        (fetch_fire),
    .pending      (redirect_pending),
    .saved_target (saved_target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    imem_req     = 1'b0;
    if_valid     = 1'b0;
    flush        = 1'b0;
    redirect_now = 1'b0;
    fetch_fire   = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req     = !stall;
        redirect_now = br_valid && take_branch;
        flush        = redirect_now;
        // An ack during stall is a protocol violation and is ignored.
        fetch_fire   = imem_ack && !stall;

        if (fetch_fire) begin
          if (redirect_now) begin
            // Wrong-path instruction dropped; fresh target wins.
            pc_d = next_address;
          end else if (redirect_pending) begin
            pc_d = saved_target;
          end else begin
            if_valid = 1'b1;
            pc_d     = next_address;
            count_d  = count_q + 1'b1;
          end
        end

        // A fetch completing this cycle still retires before halting.
        if (halt) begin
          state_d = ST_HALTED;
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign cur_address = pc_q;
  assign fetch_count = count_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the architectural PC register for the 5-stage pipeline and sequences instruction fetch.
- Drives cur_address into the program_counter datapath and receives its next_address (PC+4 or branch target) and take_branch outputs.
- Handles the instruction-memory request/acknowledge handshake, IF-stage stalls from the hazard unit, taken-branch redirects with IF/ID flush, and halt.

Parameters:
- ADDR_W, 64, width of PC and all address ports.
- RESET_PC, 64'h0, PC value loaded on reset.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cur_address  output  ADDR_W  current PC; to program_counter and instruction memory.
- next_address  input  ADDR_W  combinational next PC from program_counter.
- take_branch  input  1  TakeBranch from program_counter; meaningful only when br_valid=1.
- br_valid  input  1  a branch is resolving this cycle.
- stall  input  1  hazard unit holds the IF stage.
- halt  input  1  stop fetching; sticky until reset.
- imem_req  output  1  fetch request for cur_address.
- imem_ack  input  1  instruction for cur_address is returned this cycle.
- if_valid  output  1  write enable/valid into the IF/ID register.
- flush  output  1  kill the IF/ID contents (wrong-path instruction).
- fetch_count  output  CNT_W  number of if_valid pulses since reset; wraps.

Behaviour:
- Reset (async, any state):
  - cur_address=RESET_PC, state=BOOT, redirect_pending=0, saved_target=0, fetch_count=0.
  - imem_req, if_valid and flush are all 0.
- States:
  - BOOT: one idle cycle after reset deasserts, with imem_req=0. Always transitions to FETCH.
  - FETCH: imem_req = !stall.
  - HALTED: imem_req=0, if_valid=0, and the PC is frozen. Exit only via reset.
- Redirect capture (FETCH, any cycle): if br_valid && take_branch, set redirect_pending=1, set saved_target=next_address, and assert flush=1 for exactly that cycle.
- Fetch completion (FETCH, imem_ack=1, stall=0):
  - Redirect pending or arriving this cycle: discard the returned instruction (if_valid=0), load PC from the target (the arriving next_address when br_valid && take_branch this cycle, otherwise saved_target), and clear redirect_pending.
  - Otherwise: if_valid=1, PC <= next_address, fetch_count += 1.
  - Latency: one instruction per cycle when imem_ack is held high, with no stall and no redirect.
- Stall (FETCH, stall=1):
  - imem_req=0, PC holds, if_valid=0.
  - Redirects are still captured into the pending register and applied after stall drops (stall does not block capture; redirect takes priority on the PC).
  - imem_ack seen while stall=1 is a protocol violation; it is ignored with no state change.
- Waiting for memory (FETCH, no imem_ack): PC holds and the request remains asserted.
- Back-to-back redirects: the second overwrites saved_target; last wins.
- Halt: sampled in FETCH.
  - Halt with no fetch in flight (no ack this cycle): go to HALTED immediately.
  - Halt with ack this cycle: complete the fetch per the rules above, then enter HALTED next cycle.
  - A redirect arriving while HALTED is ignored; flush=0.
- fetch_count wraps from all-ones to 0.
- All outputs are registered except imem_req, if_valid and flush, which are Moore/Mealy combinational from state plus inputs. No combinational path from next_address to any output.

Decomposition:
- Shared pipeline package:
  - state encoding localparams: ST_BOOT=2'd0, ST_FETCH=2'd1, ST_HALTED=2'd2.
  - ADDR_W default.
  - INSTR_BYTES=4.
- One natural sub-module: redirect_buffer, holding redirect_pending and saved_target, with capture/clear/overwrite logic.
- The FSM and counter stay in the top level.

Test Plan:
- Reset and boot: reset high, then release; imem_ack tied 1, next_address=cur+4.
  - Cycle 0 after release: BOOT, imem_req=0.
  - Then cur_address = 0x0, 0x4, 0x8 on consecutive cycles; if_valid=1 each; fetch_count=3 after 3 fetches.
- Branch with immediate ack: at PC=0x10, br_valid=1, take_branch=1, next_address=0x40, imem_ack=1.
  - Required: flush=1, if_valid=0, next cycle cur_address=0x40, fetch_count unchanged.
- Branch during stall: stall=1 at PC=0x20; branch to 0x80 pulses for one cycle; stall released 3 cycles later with next_address now 0x24.
  - Required: PC holds 0x20 during stall, imem_req=0.
  - On first ack after release: if_valid=0, PC becomes 0x80.
- Slow memory: imem_ack low for 4 cycles at PC=0x8.
  - Required: imem_req=1 and cur_address=0x8 throughout; one if_valid on ack; PC then 0xC.
- Halt: halt=1 at PC=0x30 with ack.
  - Required: that fetch completes (if_valid=1, PC becomes 0x34), then HALTED with imem_req=0.
  - A later branch pulse produces no flush and no PC change.
  - Asserting reset mid-halt returns cur_address=RESET_PC asynchronously with fetch_count=0.
- Counter wrap: CNT_W=4; run 17 valid fetches.
  - Required: fetch_count reads 0xF after 15, 0x0 after 16, 0x1 after 17.
